flash_qspi_reader: RTL and testbench

//  Sequences quad-I/O fast reads (cmd 0xEB) from the SST26-class program flash on the Sys0 S0 flash pins.

---
 rtl/flash_qspi_reader.sv | 202 ++++++++++++++++++++
 tb/tb_flash_qspi_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/flash_qspi_reader.sv
// flash_qspi_reader: single-word quad-I/O fast read (0xEB) sequencer for an
// SST26-class serial flash. One 24-bit request in, one little-endian 32-bit
// word out. SCK runs at HCLK/2; every pad output comes straight from a flop.
module flash_qspi_reader #(
    parameter int unsigned DUMMY_CYCLES = 4,
    parameter int unsigned CS_HIGH_MIN  = 2,
    parameter logic [7:0]  MODE_BYTE    = 8'hFF
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        busy,
    input  logic [3:0]  fdi,
    output logic [3:0]  fdo,
    output logic        fdoe,
    output logic        fsclk,
    output logic        fcen
);

    localparam logic [7:0]  CMD_QIO_READ = 8'hEB;
    localparam int unsigned CNT_MAX      = (DUMMY_CYCLES > 8) ? DUMMY_CYCLES : 8;
    localparam int unsigned CNT_W        = $clog2(CNT_MAX);
    localparam int unsigned CSC_W        = (CS_HIGH_MIN > 1) ? $clog2(CS_HIGH_MIN + 1) : 1;
    // The accepting IDLE cycle is itself a CS-high cycle, so readiness needs
    // only CS_HIGH_MIN-1 earlier high cycles.
    localparam logic [CSC_W-1:0] CS_THR  = CSC_W'(CS_HIGH_MIN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_MODE,
        S_DUMMY,
        S_DATA,
        S_CSH
    } state_e;

    state_e             state_q, state_d;
    logic               phase_q, phase_d;      // 0: SCK low half, 1: SCK high half
    logic [CNT_W-1:0]   cnt_q, cnt_d;          // SCK count within the current phase
    logic [23:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;        // assembly buffer, never visible
    logic [31:0]        rdata_q, rdata_d;
    logic               rdata_valid_q, rdata_valid_d;
    logic [CSC_W-1:0]   cs_cnt_q, cs_cnt_d;    // CS-high cycles already elapsed
    logic               fcen_q, fcen_d;
    logic               fsclk_q, fsclk_d;
    logic               fdoe_q, fdoe_d;
    logic [3:0]         fdo_q, fdo_d;
    logic               busy_q, busy_d;
    logic [4:0]         nib_pos;

    // Last SCK index of each serial phase.
    function automatic logic [CNT_W-1:0] last_cnt(input state_e s);
        case (s)
            S_CMD:   last_cnt = CNT_W'(7);
            S_ADDR:  last_cnt = CNT_W'(5);
            S_MODE:  last_cnt = CNT_W'(1);
            S_DUMMY: last_cnt = CNT_W'(DUMMY_CYCLES - 1);
            default: last_cnt = CNT_W'(7);
        endcase
    endfunction

    // Phase order of the transaction.
    function automatic state_e next_phase(input state_e s);
        case (s)
            S_CMD:   next_phase = S_ADDR;
            S_ADDR:  next_phase = S_MODE;
            S_MODE:  next_phase = S_DUMMY;
            S_DUMMY: next_phase = S_DATA;
            S_DATA:  next_phase = S_CSH;
            default: next_phase = S_IDLE;
        endcase
    endfunction

    // Address nibble n, most significant first.
    function automatic logic [3:0] addr_nibble(input logic [23:0] a, input logic [2:0] n);
        case (n)
            3'd0:    addr_nibble = a[23:20];
            3'd1:    addr_nibble = a[19:16];
            3'd2:    addr_nibble = a[15:12];
            3'd3:    addr_nibble = a[11:8];
            3'd4:    addr_nibble = a[7:4];
            3'd5:    addr_nibble = a[3:0];
            default: addr_nibble = 4'hF;
        endcase
    endfunction

    // Next-state, SCK sequencing, CS-high timing and read-data assembly.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        data_d        = data_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        cs_cnt_d      = cs_cnt_q;
        req_ready     = (state_q == S_IDLE) && (cs_cnt_q >= CS_THR);
        // Byte k = cnt/2 lands at [8k+7:8k]; even nibble is the high half.
        nib_pos       = {cnt_q[2:1], ~cnt_q[0], 2'b00};

        if ((state_q == S_IDLE || state_q == S_CSH) && cs_cnt_q < CS_THR)
            cs_cnt_d = cs_cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d   = req_addr;
                    state_d  = S_CMD;
                    phase_d  = 1'b0;
                    cnt_d    = '0;
                    cs_cnt_d = '0;
                end
            end
            S_CSH: begin
                // Remaining CS-high time is counted in IDLE via cs_cnt.
                state_d = S_IDLE;
            end
            default: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (state_q == S_DATA)
                        data_d[nib_pos +: 4] = fdi;
                    if (cnt_q == last_cnt(state_q)) begin
                        cnt_d   = '0;
                        state_d = next_phase(state_q);
                        if (state_q == S_DATA) begin
                            rdata_d       = data_d;
                            rdata_valid_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // Pad values for the coming cycle, decoded from the next state so they register cleanly.
    always_comb begin
        fcen_d  = (state_d == S_IDLE) || (state_d == S_CSH);
        busy_d  = !fcen_d;
        fsclk_d = !fcen_d && phase_d;
        fdoe_d  = (state_d == S_CMD) || (state_d == S_ADDR) || (state_d == S_MODE);
        fdo_d   = 4'hF;
        case (state_d)
            S_CMD:   fdo_d = {3'b111, CMD_QIO_READ[3'd7 - cnt_d[2:0]]};
            S_ADDR:  fdo_d = addr_nibble(addr_d, cnt_d[2:0]);
            S_MODE:  fdo_d = cnt_d[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
            default: fdo_d = 4'hF;
        endcase
    end

    // State and output registers; reset drops the flash bus to idle immediately.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= S_IDLE;
            phase_q       <= 1'b0;
            cnt_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            cs_cnt_q      <= CS_THR;
            fcen_q        <= 1'b1;
            fsclk_q       <= 1'b0;
            fdoe_q        <= 1'b0;
            fdo_q         <= 4'hF;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            cs_cnt_q      <= cs_cnt_d;
            fcen_q        <= fcen_d;
            fsclk_q       <= fsclk_d;
            fdoe_q        <= fdoe_d;
            fdo_q         <= fdo_d;
            busy_q        <= busy_d;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign busy        = busy_q;
    assign fcen        = fcen_q;
    assign fsclk       = fsclk_q;
    assign fdoe        = fdoe_q;
    assign fdo         = fdo_q;

endmodule

// File: tb/tb_flash_qspi_reader.sv
// Directed bench for flash_qspi_reader with a behavioural quad-I/O flash.
module tb_flash_qspi_reader;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req_valid = 1'b0;
    logic [23:0] req_addr = 24'h0;
    logic        req_ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        busy;
    logic [3:0]  fdi = 4'h0;
    logic [3:0]  fdo;
    logic        fdoe;
    logic        fsclk;
    logic        fcen;

    int tests = 0;
    int fails = 0;

    flash_qspi_reader dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy),
        .fdi(fdi), .fdo(fdo), .fdoe(fdoe), .fsclk(fsclk), .fcen(fcen)
    );

    always #5 HCLK = ~HCLK;

    // Flash contents: 11 22 33 44 at 0..3, a fixed hash elsewhere.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000000: return 8'h11;
            24'h000001: return 8'h22;
            24'h000002: return 8'h33;
            24'h000003: return 8'h44;
            default:    return a[7:0] ^ a[23:16] ^ 8'hA5;
        endcase
    endfunction

    // Flash model: decode command/address/mode on rising SCK, check pad direction.
    int          sck_n = 0;
    logic [7:0]  m_cmd = 8'h0;
    logic [23:0] m_addr = 24'h0;
    logic [7:0]  m_mode = 8'h0;
    int          m_hi_bad = 0;
    int          m_oe_bad = 0;

    always @(negedge fcen or posedge fsclk) begin
        if (!fsclk) begin
            sck_n = 0; m_cmd = 0; m_addr = 0; m_mode = 0; m_hi_bad = 0; m_oe_bad = 0;
        end else begin
            if (sck_n < 8) begin
                m_cmd = {m_cmd[6:0], fdo[0]};
                if (fdo[3:1] !== 3'b111) m_hi_bad++;
            end else if (sck_n < 14) m_addr = {m_addr[19:0], fdo};
            else if (sck_n < 16) m_mode = {m_mode[3:0], fdo};
            if (fdoe !== (sck_n < 16)) m_oe_bad++;
            sck_n++;
        end
    end

    // Flash drives the next data nibble after each falling SCK once dummies are done.
    always @(negedge fsclk) begin
        int j;
        logic [7:0] b;
        #1;
        if (sck_n >= 20 && sck_n < 28) begin
            j = sck_n - 20;
            b = mem_byte(m_addr + 24'(j / 2));
            fdi = (j % 2 == 0) ? b[7:4] : b[3:0];
        end
    end

    task automatic do_read(input logic [23:0] a, output logic [31:0] data, output int lat);
        int n;
        @(negedge HCLK);
        req_valid = 1'b1; req_addr = a; n = 0;
        while (req_ready !== 1'b1 && n < 100) begin @(negedge HCLK); n++; end
        if (n >= 100) begin
            tests++; fails++;
            $display("FAIL accept_timeout: req_ready never high for addr %h", a);
        end
        @(negedge HCLK);
        req_valid = 1'b0; req_addr = ~a;
        lat = 1;
        while (rdata_valid !== 1'b1 && lat < 200) begin @(negedge HCLK); lat++; end
        data = rdata;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge HCLK);
        tests++; if (fcen !== 1'b1) begin fails++; $display("FAIL rst_fcen: got %b expected 1", fcen); end
        tests++; if (fsclk !== 1'b0) begin fails++; $display("FAIL rst_fsclk: got %b expected 0", fsclk); end
        tests++; if (fdoe !== 1'b0) begin fails++; $display("FAIL rst_fdoe: got %b expected 0", fdoe); end
        tests++; if (fdo !== 4'hF) begin fails++; $display("FAIL rst_fdo: got %h expected f", fdo); end
        tests++; if ({rdata_valid, busy, rdata} !== 34'h0) begin
            fails++; $display("FAIL rst_misc: got vld=%b busy=%b rdata=%h expected 0", rdata_valid, busy, rdata);
        end
        HRESETn = 1'b1;
        @(negedge HCLK);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] d; int lat;
        do_read(24'h000000, d, lat);
        tests++; if (d !== 32'h44332211) begin fails++; $display("FAIL basic_data: got %h expected 44332211", d); end
        tests++; if (lat !== 57) begin fails++; $display("FAIL basic_latency: got %0d expected 57", lat); end
        repeat (5) @(negedge HCLK);
        tests++; if (rdata !== 32'h44332211 || rdata_valid !== 1'b0) begin
            fails++; $display("FAIL basic_hold: got rdata=%h vld=%b expected 44332211 0", rdata, rdata_valid);
        end
        tests++; if (fcen !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL basic_idle: got fcen=%b busy=%b expected 1 0", fcen, busy);
        end
    endtask

    task automatic test_bus();
        logic [31:0] d; int lat;
        do_read(24'hABCDE1, d, lat);
        tests++; if (m_cmd !== 8'hEB) begin fails++; $display("FAIL bus_cmd: got %h expected eb", m_cmd); end
        tests++; if (m_hi_bad !== 0) begin fails++; $display("FAIL bus_cmd_hi: got %0d bad SCK expected 0", m_hi_bad); end
        tests++; if (m_addr !== 24'hABCDE1) begin fails++; $display("FAIL bus_addr: got %h expected abcde1", m_addr); end
        tests++; if (m_mode !== 8'hFF) begin fails++; $display("FAIL bus_mode: got %h expected ff", m_mode); end
        tests++; if (m_oe_bad !== 0) begin fails++; $display("FAIL bus_fdoe: got %0d bad SCK expected 0", m_oe_bad); end
        tests++; if (sck_n !== 28) begin fails++; $display("FAIL bus_sck_count: got %0d expected 28", sck_n); end
        tests++; if (d !== 32'hEAEDECEF) begin fails++; $display("FAIL bus_data: got %h expected eaedecef", d); end
    endtask

    task automatic test_back_to_back();
        int pulses, gap, run, bad;
        logic prev;
        pulses = 0; gap = -1; run = 0; bad = 0;
        @(negedge HCLK);
        req_valid = 1'b1; req_addr = 24'h000000;
        prev = fcen;
        for (int k = 0; k < 400 && pulses < 2; k++) begin
            @(negedge HCLK);
            if (rdata_valid === 1'b1) begin
                pulses++;
                if (rdata !== 32'h44332211) bad++;
            end
            if (fcen === 1'b1) run++;
            else begin
                if (prev === 1'b1 && pulses >= 1 && gap < 0) gap = run;
                run = 0;
            end
            prev = fcen;
        end
        req_valid = 1'b0;
        tests++; if (pulses !== 2) begin fails++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
        tests++; if (gap !== 2) begin fails++; $display("FAIL b2b_cs_gap: got %0d expected 2", gap); end
        tests++; if (bad !== 0) begin fails++; $display("FAIL b2b_data: got %0d bad words expected 0", bad); end
    endtask

    task automatic test_busy_ignore();
        int n, pulses, rdy_bad, vcyc;
        logic [31:0] val;
        pulses = 0; rdy_bad = 0; vcyc = -1; val = 32'h0;
        repeat (4) @(negedge HCLK);
        req_valid = 1'b1; req_addr = 24'h000004; n = 0;
        while (req_ready !== 1'b1 && n < 100) begin @(negedge HCLK); n++; end
        for (int k = 1; k <= 75; k++) begin
            @(negedge HCLK);
            if (k <= 56 && req_ready !== 1'b0) rdy_bad++;
            if (rdata_valid === 1'b1) begin pulses++; val = rdata; if (vcyc < 0) vcyc = k; end
            req_valid = (k >= 44 && k <= 46);
            req_addr = 24'h000010;
        end
        req_valid = 1'b0;
        tests++; if (pulses !== 1) begin fails++; $display("FAIL busy_pulses: got %0d expected 1", pulses); end
        tests++; if (val !== 32'hA2A3A0A1) begin fails++; $display("FAIL busy_data: got %h expected a2a3a0a1", val); end
        tests++; if (vcyc !== 57) begin fails++; $display("FAIL busy_latency: got %0d expected 57", vcyc); end
        tests++; if (rdy_bad !== 0) begin fails++; $display("FAIL busy_ready: got %0d cycles ready expected 0", rdy_bad); end
        tests++; if (fcen !== 1'b1) begin fails++; $display("FAIL busy_no_restart: got fcen=%b expected 1", fcen); end
    endtask

    task automatic test_reset_mid();
        int n, lat;
        logic [31:0] d;
        @(negedge HCLK);
        req_valid = 1'b1; req_addr = 24'hABCDE1; n = 0;
        while (req_ready !== 1'b1 && n < 100) begin @(negedge HCLK); n++; end
        for (int k = 1; k <= 20; k++) begin
            @(negedge HCLK);
            req_valid = 1'b0;
        end
        tests++; if (fcen !== 1'b0 || fsclk !== 1'b1) begin
            fails++; $display("FAIL rstmid_pre: got fcen=%b fsclk=%b expected 0 1", fcen, fsclk);
        end
        HRESETn = 1'b0;
        #1;
        tests++; if ({fcen, fsclk, fdoe, busy} !== 4'b1000) begin
            fails++; $display("FAIL rstmid_pads: got fcen=%b fsclk=%b fdoe=%b busy=%b expected 1 0 0 0", fcen, fsclk, fdoe, busy);
        end
        tests++; if (rdata !== 32'h0 || fdo !== 4'hF) begin
            fails++; $display("FAIL rstmid_state: got rdata=%h fdo=%h expected 0 f", rdata, fdo);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        do_read(24'h000000, d, lat);
        tests++; if (d !== 32'h44332211) begin fails++; $display("FAIL rstmid_data: got %h expected 44332211", d); end
        tests++; if (lat !== 57) begin fails++; $display("FAIL rstmid_latency: got %0d expected 57", lat); end
    endtask

    task automatic test_wrap();
        logic [31:0] d; int lat;
        do_read(24'hFFFFFE, d, lat);
        tests++; if (d !== 32'h2211A5A4) begin fails++; $display("FAIL wrap_data: got %h expected 2211a5a4", d); end
        tests++; if (lat !== 57) begin fails++; $display("FAIL wrap_latency: got %0d expected 57", lat); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_bus();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
